// File: rtl/axis_rom_rr_arbiter.sv
// Round-robin sharing of one fixed-latency ROM read port between NUM AXI-stream requesters.
// Define AXIS_ROM_ARB_PKT_LOCK_EN to hold the grant on one requester until its tlast beat.
module axis_rom_rr_arbiter #(
  parameter int NUM    = 2,
  parameter int ASIZE  = 16,
  parameter int DSIZE  = 32,
  parameter int RLAT   = 2,
  parameter int FDEPTH = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NUM*ASIZE-1:0]   req_addr,
  input  logic [NUM-1:0]         req_valid,
  input  logic [NUM-1:0]         req_last,
  output logic [NUM-1:0]         req_ready,
  output logic [ASIZE-1:0]       rom_addr,
  output logic                   rom_en,
  input  logic [DSIZE-1:0]       rom_dout,
  output logic [NUM*DSIZE-1:0]   rsp_data,
  output logic [NUM-1:0]         rsp_valid,
  output logic [NUM-1:0]         rsp_last,
  input  logic [NUM-1:0]         rsp_ready
);
  localparam int IW = $clog2(NUM);
  localparam int AW = $clog2(FDEPTH);
  localparam int CW = $clog2(FDEPTH + 1);

  logic [IW-1:0]    ptr;
  logic [NUM-1:0]   elig;
  logic [NUM-1:0]   grant;
  logic [NUM-1:0]   rsp_hs;
  logic [IW-1:0]    gidx;
  logic             acc;
  logic             acc_last;
  logic [ASIZE-1:0] acc_addr;

  logic [RLAT:0]    tag_vld_p;
  logic [RLAT:0]    tag_last_p;
  logic [IW-1:0]    tag_idx_p [RLAT+1];
  logic             ret_vld;
  logic [IW-1:0]    ret_idx;

`ifdef AXIS_ROM_ARB_PKT_LOCK_EN
  logic             lock;
  logic [IW-1:0]    lock_idx;
`endif

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM) s = s - NUM;
    return IW'(s);
  endfunction

  function automatic logic [CW-1:0] next_credit(input logic [CW-1:0] c, input logic dec,
                                                input logic inc);
    logic [CW-1:0] n;
    n = c;
    if (dec && !inc && c != '0) n = c - 1'b1;
    else if (inc && !dec && c != CW'(FDEPTH)) n = c + 1'b1;
    return n;
  endfunction

  // Stage p0: combinational grant, searched from ptr with wrap; later offsets are overridden.
  always_comb begin
    grant = '0;
    gidx  = '0;
    if (!rst) begin
`ifdef AXIS_ROM_ARB_PKT_LOCK_EN
      if (lock) begin
        grant[lock_idx] = elig[lock_idx];
        gidx            = lock_idx;
      end else begin
`endif
        for (int k = NUM - 1; k >= 0; k--) begin
          if (elig[rr_idx(ptr, k)]) begin
            grant                = '0;
            grant[rr_idx(ptr, k)] = 1'b1;
            gidx                 = rr_idx(ptr, k);
          end
        end
`ifdef AXIS_ROM_ARB_PKT_LOCK_EN
      end
`endif
    end
  end

  assign req_ready = grant;
  assign acc       = |grant;
  assign acc_addr  = req_addr[gidx*ASIZE +: ASIZE];
  assign acc_last  = req_last[gidx];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      rom_addr  <= '0;
      tag_vld_p <= '0;
`ifdef AXIS_ROM_ARB_PKT_LOCK_EN
      lock      <= 1'b0;
      lock_idx  <= '0;
`endif
    end else begin
      tag_vld_p <= {tag_vld_p[RLAT-1:0], acc};
      if (acc) begin
        rom_addr <= acc_addr;
        ptr      <= rr_idx(gidx, 1);
`ifdef AXIS_ROM_ARB_PKT_LOCK_EN
        lock     <= !acc_last;
        lock_idx <= gidx;
`endif
      end
    end
  end

  // Stage p1..p(RLAT): tag travels with the ROM read so returning data finds its FIFO.
  always_ff @(posedge clock) begin
    tag_last_p   <= {tag_last_p[RLAT-1:0], acc_last};
    tag_idx_p[0] <= gidx;
    for (int s = 1; s <= RLAT; s++) tag_idx_p[s] <= tag_idx_p[s-1];
  end

  assign rom_en  = tag_vld_p[0];
  assign ret_vld = tag_vld_p[RLAT];
  assign ret_idx = tag_idx_p[RLAT];

  for (genvar i = 0; i < NUM; i++) begin : g_req
    logic [DSIZE:0]  mem [FDEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   credit;
    logic            wr;

    assign wr        = ret_vld && (ret_idx == IW'(i));
    assign elig[i]   = req_valid[i] && (credit != '0);
    assign rsp_valid[i] = (cnt != '0);
    assign rsp_hs[i] = rsp_valid[i] && rsp_ready[i];
    assign rsp_data[i*DSIZE +: DSIZE] = rsp_valid[i] ? mem[rd_ptr][DSIZE:1] : '0;
    assign rsp_last[i] = rsp_valid[i] && mem[rd_ptr][0];

    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        credit <= CW'(FDEPTH);
      end else begin
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (rsp_hs[i]) rd_ptr <= rd_ptr + 1'b1;
        if (wr && !rsp_hs[i]) cnt <= cnt + 1'b1;
        else if (!wr && rsp_hs[i]) cnt <= cnt - 1'b1;
        credit <= next_credit(credit, grant[i], rsp_hs[i]);
      end
    end

    // Stage p(RLAT+1): returning word lands in the FIFO; credit guarantees a free slot.
    always_ff @(posedge clock) begin
      if (wr) mem[wr_ptr] <= {rom_dout, tag_last_p[RLAT]};
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (rst)
                                    !(wr && cnt == CW'(FDEPTH)))
      else $error("response FIFO %0d written while full", i);
  end
endmodule
